// File: rtl/jpeg_zigzag_pingpong_if.sv
// Write-side and read-side handshake bundle for the ping-pong zigzag coefficient buffer.
// The master drives writes and read-accept; the slave is the buffer.
interface jpeg_zigzag_pingpong_if #(
  parameter int unsigned DW = 16
);
  logic          DataInEnable;
  logic [5:0]    DataInAddress;
  logic [DW-1:0] DataIn;
  logic          DataInLast;
  logic          ZzMode;
  logic          DataInReady;
  logic          OutValid;
  logic          OutReady;
  logic [DW-1:0] OutData;
  logic [5:0]    OutIndex;
  logic          OutLast;
  logic [1:0]    BankFull;

  modport master (
    output DataInEnable, DataInAddress, DataIn, DataInLast, ZzMode, OutReady,
    input  DataInReady, OutValid, OutData, OutIndex, OutLast, BankFull
  );

  modport slave (
    input  DataInEnable, DataInAddress, DataIn, DataInLast, ZzMode, OutReady,
    output DataInReady, OutValid, OutData, OutIndex, OutLast, BankFull
  );
endinterface

// File: rtl/jpeg_zigzag_pingpong.sv
// Two 64-entry coefficient banks in ping-pong: zigzag (or raster) writes fill one bank
// while the other streams out in raster order under valid/ready.
module jpeg_zigzag_pingpong #(
  parameter int unsigned DW          = 16,
  parameter bit          CLEAR_ON_DC = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  jpeg_zigzag_pingpong_if.slave  bus
);

  // Zigzag index k -> raster position.
  localparam logic [5:0] ZzTable [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [DW-1:0] bank_q [2][64];
  logic [DW-1:0] bank_d [2][64];
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [5:0]    rd_cnt_q, rd_cnt_d;

  logic       wr_acc;
  logic       rd_fire;
  logic       rd_done;
  logic [5:0] wr_raster;

  assign wr_acc    = bus.DataInEnable & ~full_q[wr_bank_q];
  assign wr_raster = bus.ZzMode ? ZzTable[bus.DataInAddress] : bus.DataInAddress;
  assign rd_fire   = full_q[rd_bank_q] & bus.OutReady;
  assign rd_done   = rd_fire & (rd_cnt_q == 6'd63);

  // Raw address 0 is raster 0 in either mode, so the DC check ignores ZzMode.
  always_comb begin
    bank_d = bank_q;
    if (wr_acc) begin
      if (CLEAR_ON_DC && (bus.DataInAddress == 6'd0)) begin
        bank_d[wr_bank_q] = '{default: '0};
      end
      bank_d[wr_bank_q][wr_raster] = bus.DataIn;
    end
  end

  // A last-write and a read release can never hit the same bank, so both apply.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;
    if (wr_acc && bus.DataInLast) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 6'd1;
    end
    if (rd_done) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q    <= '{default: '{default: '0}};
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= 6'd0;
    end else begin
      bank_q    <= bank_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  assign bus.DataInReady = ~full_q[wr_bank_q];
  assign bus.OutValid    = full_q[rd_bank_q];
  assign bus.OutIndex    = rd_cnt_q;
  assign bus.OutData     = bank_q[rd_bank_q][rd_cnt_q];
  assign bus.OutLast     = full_q[rd_bank_q] & (rd_cnt_q == 6'd63);
  assign bus.BankFull    = full_q;

endmodule

// File: tb/tb_jpeg_zigzag_pingpong.sv
// Directed bench for jpeg_zigzag_pingpong: zigzag fill, bypass, DC clear, backpressure,
// simultaneous release/fill and asynchronous reset mid-read.
module tb_jpeg_zigzag_pingpong;

  logic clk;
  logic rst;

  jpeg_zigzag_pingpong_if #(.DW(16)) bus ();

  jpeg_zigzag_pingpong #(
    .DW          (16),
    .CLEAR_ON_DC (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0]  zz [64];
  logic [15:0] exp_blk [64];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic last,
                    input logic zzm);
    bus.DataInEnable  = 1'b1;
    bus.DataInAddress = a;
    bus.DataIn        = d;
    bus.DataInLast    = last;
    bus.ZzMode        = zzm;
    tick();
    bus.DataInEnable  = 1'b0;
    bus.DataInLast    = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) exp_blk[i] = 16'h0000;
  endtask

  task automatic rd_block(input string tag);
    int t = 0;
    while (!bus.OutValid && t < 200) begin
      tick();
      t++;
    end
    check_eq({tag, "_valid"}, 32'(bus.OutValid), 32'd1);
    bus.OutReady = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check_eq($sformatf("%s_idx[%0d]", tag, i), 32'(bus.OutIndex), 32'(i));
      check_eq($sformatf("%s_data[%0d]", tag, i), 32'(bus.OutData), 32'(exp_blk[i]));
      check_eq($sformatf("%s_last[%0d]", tag, i), 32'(bus.OutLast), 32'(i == 63));
      tick();
    end
    bus.OutReady = 1'b0;
  endtask

  initial begin
    zz = '{6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
           6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
           6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
           6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
           6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
           6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
           6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
           6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};

    rst               = 1'b0;
    bus.DataInEnable  = 1'b0;
    bus.DataInAddress = 6'd0;
    bus.DataIn        = 16'h0;
    bus.DataInLast    = 1'b0;
    bus.ZzMode        = 1'b1;
    bus.OutReady      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(bus.DataInReady), 32'd1);
    check_eq("rst_valid", 32'(bus.OutValid), 32'd0);
    check_eq("rst_last", 32'(bus.OutLast), 32'd0);
    check_eq("rst_index", 32'(bus.OutIndex), 32'd0);
    check_eq("rst_data", 32'(bus.OutData), 32'd0);
    check_eq("rst_full", 32'(bus.BankFull), 32'd0);
    rst = 1'b1;
    tick();

    // Full zigzag block into bank 0.
    bus.OutReady = 1'b1;
    for (int k = 0; k < 64; k++) begin
      exp_blk[zz[k]] = 16'h0100 + 16'(k);
      wr(6'(k), 16'h0100 + 16'(k), k == 63, 1'b1);
    end
    check_eq("zz_valid_after_last", 32'(bus.OutValid), 32'd1);
    check_eq("zz_full", 32'(bus.BankFull), 32'd1);
    check_eq("zz_ready", 32'(bus.DataInReady), 32'd1);
    check_eq("zz_raster2", 32'(exp_blk[2]), 32'h105);
    rd_block("zz");
    check_eq("zz_done_valid", 32'(bus.OutValid), 32'd0);
    check_eq("zz_done_full", 32'(bus.BankFull), 32'd0);

    // Raster bypass into bank 1.
    clear_exp();
    exp_blk[10] = 16'h1234;
    wr(6'd10, 16'h1234, 1'b1, 1'b0);
    check_eq("byp_full", 32'(bus.BankFull), 32'd2);
    rd_block("byp");

    // Sparse block into bank 0, which still holds the zigzag block.
    clear_exp();
    exp_blk[0] = 16'h0010;
    exp_blk[8] = 16'hFFF0;
    wr(6'd0, 16'h0010, 1'b0, 1'b1);
    wr(6'd2, 16'hFFF0, 1'b1, 1'b1);
    rd_block("sparse");

    // Backpressure: both banks fill, a third block is refused.
    bus.OutReady = 1'b0;
    wr(6'd0, 16'hA000, 1'b0, 1'b1);
    wr(6'd1, 16'hA001, 1'b1, 1'b1);
    check_eq("bp_ready_one", 32'(bus.DataInReady), 32'd1);
    wr(6'd0, 16'hB000, 1'b0, 1'b1);
    wr(6'd63, 16'hB03F, 1'b1, 1'b1);
    check_eq("bp_ready_two", 32'(bus.DataInReady), 32'd0);
    check_eq("bp_full_two", 32'(bus.BankFull), 32'd3);
    wr(6'd3, 16'hEEEE, 1'b1, 1'b1);
    check_eq("bp_ignored_full", 32'(bus.BankFull), 32'd3);
    check_eq("bp_ignored_ready", 32'(bus.DataInReady), 32'd0);
    clear_exp();
    exp_blk[0] = 16'hA000;
    exp_blk[1] = 16'hA001;
    rd_block("blkA");
    check_eq("bp_ready_after", 32'(bus.DataInReady), 32'd1);
    check_eq("bp_valid_nobubble", 32'(bus.OutValid), 32'd1);
    check_eq("bp_full_after", 32'(bus.BankFull), 32'd1);

    // Read bank 0 while refilling bank 1; last write coincides with the final beat.
    clear_exp();
    exp_blk[0]  = 16'hB000;
    exp_blk[63] = 16'hB03F;
    bus.OutReady = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check_eq($sformatf("blkB_idx[%0d]", i), 32'(bus.OutIndex), 32'(i));
      check_eq($sformatf("blkB_data[%0d]", i), 32'(bus.OutData), 32'(exp_blk[i]));
      if (i == 62) begin
        bus.DataInEnable = 1'b1; bus.DataInAddress = 6'd0; bus.DataIn = 16'hC000;
        bus.DataInLast = 1'b0; bus.ZzMode = 1'b1;
      end
      if (i == 63) begin
        check_eq("sim_full_before", 32'(bus.BankFull), 32'd1);
        bus.DataInEnable = 1'b1; bus.DataInAddress = 6'd5; bus.DataIn = 16'hC005;
        bus.DataInLast = 1'b1; bus.ZzMode = 1'b1;
      end
      tick();
      bus.DataInEnable = 1'b0;
      bus.DataInLast   = 1'b0;
    end
    check_eq("sim_full_after", 32'(bus.BankFull), 32'd2);
    check_eq("sim_valid", 32'(bus.OutValid), 32'd1);
    check_eq("sim_index", 32'(bus.OutIndex), 32'd0);
    clear_exp();
    exp_blk[0] = 16'hC000;
    exp_blk[2] = 16'hC005;
    rd_block("blkC");

    // Asynchronous reset in the middle of a readout.
    wr(6'd0, 16'hD000, 1'b0, 1'b1);
    wr(6'd1, 16'hD001, 1'b1, 1'b1);
    bus.OutReady = 1'b1;
    repeat (20) tick();
    check_eq("mid_index", 32'(bus.OutIndex), 32'd20);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(bus.OutValid), 32'd0);
    check_eq("mid_rst_full", 32'(bus.BankFull), 32'd0);
    check_eq("mid_rst_ready", 32'(bus.DataInReady), 32'd1);
    check_eq("mid_rst_index", 32'(bus.OutIndex), 32'd0);
    check_eq("mid_rst_data", 32'(bus.OutData), 32'd0);
    bus.OutReady = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
